psum_ofifo: RTL and testbench

Output FIFO between the MAC array and the sfp accumulate/ReLU stage.
- Each array column produces partial sums at its own time; this block buffers them in one FIFO per column.
- It releases a full row (one word from every column) only when all columns hold data. The row goes to sfp as one aligned bw*col vector.

---
 rtl/psum_ofifo_pkg.sv | 17 +
 rtl/ofifo_col_fifo.sv | 79 +++++++
 rtl/psum_ofifo.sv | 78 +++++++
 tb/tb_psum_ofifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_ofifo_pkg.sv
// Shared constants for the partial-sum output FIFO: default geometry and
// derived pointer/count widths.
package psum_ofifo_pkg;

  localparam int BW_DEF    = 16;
  localparam int COL_DEF   = 8;
  localparam int DEPTH_DEF = 64;

  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = PTR_W_DEF + 1;

  // Count needs one extra bit so that "exactly depth" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column synchronous FIFO with registered read data; the read data
// register holds its value until the next accepted read.
module ofifo_col_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [bw-1:0] wr_data_i,
  input  logic          rd_i,
  output logic [bw-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = cnt_width(depth);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  logic [bw-1:0]    mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [bw-1:0]    rd_data_q, rd_data_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign rd_data_o = rd_data_q;

  // Fullness/emptiness are judged on the pre-edge count, so a write into a
  // full column is dropped even when a read drains it in the same cycle.
  assign wr_ok = wr_i && !full_o;
  assign rd_ok = rd_i && !empty_o;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset; emptiness after reset comes from count_q alone.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/psum_ofifo.sv
// Per-column psum FIFOs that release aligned rows to the sfp stage only when
// every column holds at least one word.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int bw    = BW_DEF,
  parameter int col   = COL_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [bw*col-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [bw*col-1:0] out,
  output logic              out_valid,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_full,
  output logic              overflow,
  output logic              underflow
);

  logic [col-1:0] full_vec;
  logic [col-1:0] empty_vec;
  logic           rd_row;
  logic           out_valid_q, out_valid_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  // Handshake: a row transfers on a cycle where rd=1 and o_valid=1; the row
  // appears on out with out_valid=1 one cycle later. Writes need no
  // handshake; o_ready only advises the producer that no column is full.
  assign rd_row = rd && o_valid;

  for (genvar gi = 0; gi < col; gi++) begin : g_col
    ofifo_col_fifo #(
      .bw   (bw),
      .depth(depth)
    ) u_col (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (wr[gi]),
      .wr_data_i(in[bw*gi +: bw]),
      .rd_i     (rd_row),
      .rd_data_o(out[bw*gi +: bw]),
      .full_o   (full_vec[gi]),
      .empty_o  (empty_vec[gi])
    );
  end

  assign o_valid = ~|empty_vec;
  assign o_ready = ~|full_vec;
  assign o_full  = |full_vec;

  always_comb begin
    out_valid_d = rd_row;
    overflow_d  = overflow_q  | (|(wr & full_vec));
    underflow_d = underflow_q | (rd & ~o_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: a directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based row model.
module tb_psum_ofifo;

  localparam int BW    = 16;
  localparam int COL   = 8;
  localparam int DEPTH = 64;
  localparam int W     = BW * COL;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           out_valid, o_valid, o_ready, o_full, overflow, underflow;

  psum_ofifo #(.bw(BW), .col(COL), .depth(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .wr       (wr),
    .rd       (rd),
    .out      (out),
    .out_valid(out_valid),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_full   (o_full),
    .overflow (overflow),
    .underflow(underflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [BW-1:0] mq [COL][$];
  logic [W-1:0]  exp_out;
  logic          exp_out_valid;
  logic          exp_ovf;
  logic          exp_udf;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_valid();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_any_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  task automatic compare_model();
    chk("out", out, exp_out);
    chk("out_valid", W'(out_valid), W'(exp_out_valid));
    chk("o_valid", W'(o_valid), W'(model_valid()));
    chk("o_ready", W'(o_ready), W'(!model_any_full()));
    chk("o_full", W'(o_full), W'(model_any_full()));
    chk("overflow", W'(overflow), W'(exp_ovf));
    chk("underflow", W'(underflow), W'(exp_udf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [COL-1:0] w,
                      input logic [W-1:0] d, input logic r);
    logic valid_pre;
    logic full_pre [COL];
    reset = rst;
    wr    = w;
    in    = d;
    rd    = r;
    if (rst) begin
      for (int c = 0; c < COL; c++) mq[c].delete();
      exp_out       = '0;
      exp_out_valid = 1'b0;
      exp_ovf       = 1'b0;
      exp_udf       = 1'b0;
    end else begin
      valid_pre = model_valid();
      for (int c = 0; c < COL; c++) full_pre[c] = (mq[c].size() == DEPTH);
      exp_out_valid = 1'b0;
      if (r) begin
        if (valid_pre) begin
          exp_out_valid = 1'b1;
          for (int c = 0; c < COL; c++) exp_out[c*BW +: BW] = mq[c].pop_front();
        end else begin
          exp_udf = 1'b1;
        end
      end
      for (int c = 0; c < COL; c++) begin
        if (w[c]) begin
          if (full_pre[c]) exp_ovf = 1'b1;
          else mq[c].push_back(d[c*BW +: BW]);
        end
      end
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           rst;
    logic [COL-1:0] wr;
    logic [W-1:0]   din;
    logic           rd;
    logic [W-1:0]   e_out;
    logic           e_out_valid;
    logic           e_o_valid;
    logic           e_o_ready;
    logic           e_o_full;
    logic           e_ovf;
    logic           e_udf;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [W-1:0]   skew_row;
    logic [COL-1:0] mask;
    int             rd_pct;

    reset = 1'b1;
    wr    = '0;
    in    = '0;
    rd    = 1'b0;
    exp_out = '0;
    exp_out_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;

    for (int i = 0; i < COL; i++) skew_row[i*BW +: BW] = BW'(100 + i);

    tbl[0] = '{1'b1, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < COL; k++) begin
      mask = '0;
      mask[k] = 1'b1;
      tbl[1+k] = '{1'b0, mask, skew_row, 1'b0, '0, 1'b0, (k == COL-1), 1'b1, 1'b0, 1'b0, 1'b0};
    end
    tbl[9]  = '{1'b0, '0, '0, 1'b1, skew_row, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, '0, '0, 1'b0, skew_row, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, '0, '0, 1'b1, skew_row, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset, skewed fill, single row read, idle hold, underflow on empty.
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].rst, tbl[k].wr, tbl[k].din, tbl[k].rd);
      chk($sformatf("tbl%0d_out", k), out, tbl[k].e_out);
      chk($sformatf("tbl%0d_out_valid", k), W'(out_valid), W'(tbl[k].e_out_valid));
      chk($sformatf("tbl%0d_o_valid", k), W'(o_valid), W'(tbl[k].e_o_valid));
      chk($sformatf("tbl%0d_o_ready", k), W'(o_ready), W'(tbl[k].e_o_ready));
      chk($sformatf("tbl%0d_o_full", k), W'(o_full), W'(tbl[k].e_o_full));
      chk($sformatf("tbl%0d_overflow", k), W'(overflow), W'(tbl[k].e_ovf));
      chk($sformatf("tbl%0d_underflow", k), W'(underflow), W'(tbl[k].e_udf));
    end

    // Fill to full, overflow with data intact, drain in order.
    step(1'b1, '0, '0, 1'b0);
    for (int j = 0; j < DEPTH; j++) begin
      chk("fill_not_full", W'(o_full), W'(0));
      step(1'b0, '1, rep(BW'(j)), 1'b0);
    end
    chk("full_o_full", W'(o_full), W'(1));
    chk("full_o_ready", W'(o_ready), W'(0));
    step(1'b0, '1, rep(16'hBEEF), 1'b0);
    chk("full_overflow", W'(overflow), W'(1));
    // Read and write together while full: write is dropped, read proceeds.
    step(1'b0, '1, rep(16'hDEAD), 1'b1);
    chk("full_rdwr_out", out, rep(BW'(0)));
    chk("full_rdwr_ready", W'(o_ready), W'(1));
    for (int j = 1; j < DEPTH; j++) begin
      step(1'b0, '0, '0, 1'b1);
      chk("drain_out", out, rep(BW'(j)));
      chk("drain_out_valid", W'(out_valid), W'(1));
    end
    chk("drain_empty", W'(o_valid), W'(0));

    // Wrap-around: 3 rows preloaded, then 100 cycles of write+read.
    step(1'b1, '0, '0, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, '1, rand_row(), 1'b0);
    for (int j = 0; j < 100; j++) begin
      step(1'b0, '1, rand_row(), 1'b1);
      chk("wrap_o_valid", W'(o_valid), W'(1));
      chk("wrap_out_valid", W'(out_valid), W'(1));
    end
    for (int j = 0; j < 3; j++) step(1'b0, '0, '0, 1'b1);
    chk("wrap_drained", W'(o_valid), W'(0));

    // Column 5 empty while the others hold data: rd ignored.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 8'hDF, rand_row(), 1'b0);
    step(1'b0, 8'hDF, rand_row(), 1'b0);
    chk("c5_o_valid", W'(o_valid), W'(0));
    step(1'b0, '0, '0, 1'b1);
    chk("c5_underflow", W'(underflow), W'(1));
    chk("c5_out_hold", out, '0);
    chk("c5_out_valid", W'(out_valid), W'(0));
    step(1'b0, 8'h20, rand_row(), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    chk("c5_after_out_valid", W'(out_valid), W'(1));

    // Reset mid-operation with 10 rows loaded and sticky flags set.
    for (int j = 0; j < 10; j++) step(1'b0, '1, rand_row(), 1'b0);
    step(1'b1, '0, '0, 1'b0);
    chk("midrst_o_valid", W'(o_valid), W'(0));
    chk("midrst_o_ready", W'(o_ready), W'(1));
    chk("midrst_udf", W'(underflow), W'(0));
    chk("midrst_out", out, '0);
    for (int j = 0; j < 3; j++) step(1'b0, '1, rand_row(), 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, '0, '0, 1'b1);
    chk("midrst_drained", W'(o_valid), W'(0));

    // Randomized traffic with phases that bias toward filling or draining.
    step(1'b1, '0, '0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      rd_pct = (p % 2 == 0) ? 15 : 85;
      for (int j = 0; j < 400; j++) begin
        step($urandom_range(0, 299) == 0, COL'($urandom), rand_row(),
             $urandom_range(0, 99) < rd_pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
